// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 core: widths, opcode encodings and the
// decoded-control bundle passed from the decoder to the datapath.
package td4_pkg;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 4;
    localparam int INSN_W = 8;

    typedef enum logic [3:0] {
        OP_ADD_A  = 4'b0000,
        OP_MOV_AB = 4'b0001,
        OP_IN_A   = 4'b0010,
        OP_MOV_AI = 4'b0011,
        OP_MOV_BA = 4'b0100,
        OP_ADD_B  = 4'b0101,
        OP_IN_B   = 4'b0110,
        OP_MOV_BI = 4'b0111,
        OP_OUT_B  = 4'b1001,
        OP_OUT_I  = 4'b1011,
        OP_JNC    = 4'b1110,
        OP_JMP    = 4'b1111
    } op_e;

    typedef enum logic [1:0] {
        SRC_A,
        SRC_B,
        SRC_IN,
        SRC_ZERO
    } src_e;

    typedef enum logic [1:0] {
        DST_A,
        DST_B,
        DST_OUT,
        DST_PC
    } dst_e;

    typedef struct packed {
        src_e src_sel;
        dst_e dst_sel;
        logic is_jmp;
        logic is_jnc;
        logic valid;
    } ctrl_t;

endpackage

// File: rtl/td4_if.sv
// Program-memory bus: the core drives the address, the ROM answers
// combinationally with the instruction byte.
import td4_pkg::*;

interface td4_if;
    logic [ADDR_W-1:0] rom_addr;
    logic [INSN_W-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/td4_decode.sv
// Purely combinational opcode decoder: maps rom_data[7:4] to the ALU source,
// the destination and the jump qualifiers. Undefined opcodes come out invalid.
import td4_pkg::*;

module td4_decode (
    input  logic [3:0] i_opcode,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '{src_sel: SRC_ZERO, dst_sel: DST_PC, is_jmp: 1'b0, is_jnc: 1'b0, valid: 1'b0};
        case (i_opcode)
            OP_ADD_A:  o_ctrl = '{SRC_A,    DST_A,   1'b0, 1'b0, 1'b1};
            OP_MOV_AB: o_ctrl = '{SRC_B,    DST_A,   1'b0, 1'b0, 1'b1};
            OP_IN_A:   o_ctrl = '{SRC_IN,   DST_A,   1'b0, 1'b0, 1'b1};
            OP_MOV_AI: o_ctrl = '{SRC_ZERO, DST_A,   1'b0, 1'b0, 1'b1};
            OP_MOV_BA: o_ctrl = '{SRC_A,    DST_B,   1'b0, 1'b0, 1'b1};
            OP_ADD_B:  o_ctrl = '{SRC_B,    DST_B,   1'b0, 1'b0, 1'b1};
            OP_IN_B:   o_ctrl = '{SRC_IN,   DST_B,   1'b0, 1'b0, 1'b1};
            OP_MOV_BI: o_ctrl = '{SRC_ZERO, DST_B,   1'b0, 1'b0, 1'b1};
            OP_OUT_B:  o_ctrl = '{SRC_B,    DST_OUT, 1'b0, 1'b0, 1'b1};
            OP_OUT_I:  o_ctrl = '{SRC_ZERO, DST_OUT, 1'b0, 1'b0, 1'b1};
            OP_JNC:    o_ctrl = '{SRC_ZERO, DST_PC,  1'b0, 1'b1, 1'b1};
            OP_JMP:    o_ctrl = '{SRC_ZERO, DST_PC,  1'b1, 1'b0, 1'b1};
            default:   ;
        endcase
    end

endmodule

// File: rtl/td4_core.sv
// Single-cycle TD4 execution core: registers A/B, carry flag, output latch
// and PC, one instruction per enabled clock from a combinational ROM.
import td4_pkg::*;

module td4_core (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    td4_if.master             rom,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic [ADDR_W-1:0] pc_dbg
);

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_out;
    logic              r_c;

    ctrl_t             w_ctrl;
    logic [DATA_W-1:0] w_im;
    logic [DATA_W-1:0] w_src;
    logic [DATA_W:0]   w_sum;
    logic              w_jump;

    td4_decode u_decode (
        .i_opcode (rom.rom_data[7:4]),
        .o_ctrl   (w_ctrl)
    );

    assign w_im = rom.rom_data[3:0];

    always_comb begin
        w_src = '0;
        case (w_ctrl.src_sel)
            SRC_A:   w_src = r_a;
            SRC_B:   w_src = r_b;
            SRC_IN:  w_src = in_port;
            default: w_src = '0;
        endcase
    end

    assign w_sum  = {1'b0, w_src} + {1'b0, w_im};
    // JNC looks at the flag left by the previous instruction, not this one's carry.
    assign w_jump = w_ctrl.valid && (w_ctrl.is_jmp || (w_ctrl.is_jnc && !r_c));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_out <= '0;
            r_c   <= 1'b0;
        end else if (en) begin
            r_pc <= w_jump ? w_im : r_pc + 4'd1;
            if (w_ctrl.valid) begin
                r_c <= w_sum[DATA_W];
                case (w_ctrl.dst_sel)
                    DST_A:   r_a   <= w_sum[DATA_W-1:0];
                    DST_B:   r_b   <= w_sum[DATA_W-1:0];
                    DST_OUT: r_out <= w_sum[DATA_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign rom.rom_addr = r_pc;
    assign pc_dbg       = r_pc;
    assign out_port     = r_out;

endmodule

// File: tb/tb_td4_core.sv
// Self-checking bench for td4_core: directed programs plus random programs,
// all compared against an instruction-level reference model of the TD4.
module tb_td4_core;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] in_port;
    logic [3:0] out_port;
    logic [3:0] pc_dbg;
    logic [7:0] rom [16];

    int totalChecks;
    int badChecks;

    logic [3:0] mA, mB, mPc, mOut;
    logic       mC;

    td4_if busIf ();

    assign busIf.rom_data = rom[busIf.rom_addr];

    td4_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .rom      (busIf.master),
        .in_port  (in_port),
        .out_port (out_port),
        .pc_dbg   (pc_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mA = 0; mB = 0; mPc = 0; mOut = 0; mC = 0;
    endtask

    // Instruction-level semantics: every defined op is "dst = src + Im, C = carry".
    task automatic modelStep(input logic [7:0] insn, input logic [3:0] inv, input logic env);
        int op, im, src, sum;
        bit taken;
        if (!env) return;
        op = int'(insn[7:4]);
        im = int'(insn[3:0]);
        taken = 0;
        case (op)
            0, 5, 9: src = (op == 0) ? int'(mA) : int'(mB);
            1:       src = int'(mB);
            4:       src = int'(mA);
            2, 6:    src = int'(inv);
            default: src = 0;
        endcase
        sum = src + im;
        case (op)
            0, 1, 2, 3: mA = 4'(sum % 16);
            4, 5, 6, 7: mB = 4'(sum % 16);
            9, 11:      mOut = 4'(sum % 16);
            14:         taken = (mC == 1'b0);
            15:         taken = 1;
            default:    ;
        endcase
        if (op inside {0, 1, 2, 3, 4, 5, 6, 7, 9, 11, 14, 15})
            mC = (sum >= 16);
        mPc = taken ? 4'(im) : 4'((int'(mPc) + 1) % 16);
    endtask

    task automatic applyStimulus(input logic env, input logic [3:0] inv);
        en = env;
        in_port = inv;
        modelStep(rom[mPc], inv, env);
        @(posedge clk);
        #1;
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, "_pc"},   {4'b0, pc_dbg},         {4'b0, mPc});
        checkOutput({tag, "_addr"}, {4'b0, busIf.rom_addr}, {4'b0, mPc});
        checkOutput({tag, "_out"},  {4'b0, out_port},       {4'b0, mOut});
        checkOutput({tag, "_a"},    {4'b0, dut.r_a},        {4'b0, mA});
        checkOutput({tag, "_b"},    {4'b0, dut.r_b},        {4'b0, mB});
        checkOutput({tag, "_c"},    {7'b0, dut.r_c},        {7'b0, mC});
    endtask

    // Called #1 after an edge: assert reset between edges, check, release.
    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll(tag);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fillRom(input logic [7:0] value);
        for (int i = 0; i < 16; i++) rom[i] = value;
    endtask

    initial begin
        totalChecks = 0;
        badChecks = 0;
        rst_n = 1'b0;
        en = 1'b1;
        in_port = 4'd5;
        fillRom(8'h80);
        modelReset();
        @(posedge clk);
        #1;

        // Test-plan program: B ends at 7, which is written to the output port.
        rom[0] = 8'h70; rom[1] = 8'h20; rom[2] = 8'h01; rom[3] = 8'h01;
        rom[4] = 8'h40; rom[5] = 8'h90; rom[6] = 8'hF6;
        doReset("rst0");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 4'd5);
            compareAll("prog1");
        end
        checkOutput("prog1_out7", {4'b0, out_port}, 8'd7);
        checkOutput("prog1_b7", {4'b0, dut.r_b}, 8'd7);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'd5);
            compareAll("loop");
            checkOutput("loop_pc6", {4'b0, pc_dbg}, 8'd6);
            checkOutput("loop_out7", {4'b0, out_port}, 8'd7);
        end
        #2;
        doReset("midrst");
        checkOutput("midrst_out0", {4'b0, out_port}, 8'd0);
        applyStimulus(1'b1, 4'd5);
        compareAll("refetch");
        checkOutput("refetch_pc1", {4'b0, pc_dbg}, 8'd1);

        // Carry wrap, JNC not taken, en freeze, JNC taken, OUT Im.
        fillRom(8'h80);
        rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hE9; rom[3] = 8'h30;
        rom[4] = 8'hE9; rom[9] = 8'hBA; rom[10] = 8'hFA;
        doReset("rst1");
        applyStimulus(1'b1, 4'd3);
        applyStimulus(1'b1, 4'd3);
        compareAll("wrap");
        checkOutput("wrap_a0", {4'b0, dut.r_a}, 8'd0);
        checkOutput("wrap_c1", {7'b0, dut.r_c}, 8'd1);
        applyStimulus(1'b1, 4'd3);
        checkOutput("jnc_not_taken", {4'b0, pc_dbg}, 8'd3);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'($urandom_range(0, 15)));
            compareAll("freeze");
            checkOutput("freeze_addr3", {4'b0, busIf.rom_addr}, 8'd3);
        end
        applyStimulus(1'b1, 4'd3);
        applyStimulus(1'b1, 4'd3);
        checkOutput("jnc_taken", {4'b0, pc_dbg}, 8'd9);
        applyStimulus(1'b1, 4'd3);
        compareAll("outim");
        checkOutput("outim_10", {4'b0, out_port}, 8'd10);
        checkOutput("outim_c0", {7'b0, dut.r_c}, 8'd0);

        // All-NOP program: only the PC moves, and it wraps 15 -> 0.
        fillRom(8'h80);
        doReset("rst2");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 4'($urandom_range(0, 15)));
            compareAll("nop");
            if (i == 15) checkOutput("nop_wrap0", {4'b0, pc_dbg}, 8'd0);
        end

        // Random programs, random input port and random enable gaps.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
            doReset("rstR");
            for (int i = 0; i < 80; i++) begin
                applyStimulus(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
                compareAll("rand");
            end
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/td4_core.md
# td4_core

- Single-cycle execution core for the 4-bit TD4 CPU; the initiator on the program-memory interface.
- Drives a 4-bit instruction address and consumes the 8-bit instruction returned combinationally by the program ROM.
- Holds registers A and B, the carry flag C and the output port latch; executes one instruction per enabled clock.
- Sits between the program ROM and the board-level input switches and output LEDs.

## Interface
Parameters:
- none (architecture fixed at 4-bit data, 4-bit address, 8-bit instruction)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  execute enable; low freezes all state (single-step/clock-divider hook)
- rom_addr  out  4  instruction address = PC
- rom_data  in  8  instruction; [7:4] opcode, [3:0] immediate Im
- in_port  in  4  external input, read by IN instructions
- out_port  out  4  registered output port
- pc_dbg  out  4  copy of PC for debug/LEDs

## Operation
- ALU: 4-bit adder, sum = src + Im; carry_out = bit 4 of the 5-bit result; sum wraps modulo 16.
- Opcode decode (src, destination):
  - 0000 ADD A,Im: A, A
  - 0001 MOV A,B: B, A
  - 0010 IN A: in_port, A
  - 0011 MOV A,Im: 0, A
  - 0100 MOV B,A: A, B
  - 0101 ADD B,Im: B, B
  - 0110 IN B: in_port, B
  - 0111 MOV B,Im: 0, B
  - 1001 OUT B: B, out_port
  - 1011 OUT Im: 0, out_port
  - 1110 JNC Im: 0, PC, taken only if C==0
  - 1111 JMP Im: 0, PC
- Carry:
  - C <= carry_out on every executed defined instruction, including jumps (src 0, so C <= 0).
  - JNC tests C as it was before the current edge, i.e. the flag from the previous instruction.
- PC:
  - Jump taken: PC <= Im.
  - Otherwise PC <= PC+1, wrapping 15 -> 0.
- Undefined opcodes (1000, 1010, 1100, 1101): NOP. PC <= PC+1; A, B, C and out_port unchanged.
- en low: no register, flag, PC or output change; rom_addr stays stable.

## Timing
- Reset (async assert, state cleared immediately): PC=0, A=0, B=0, C=0, out_port=0, rom_addr=0, pc_dbg=0.
- Reset deassertion: the first enabled rising edge executes the instruction at address 0.
- rom_addr comes from the PC register; rom_data must settle within the same cycle (combinational ROM). Latency is one cycle per instruction.
- in_port is sampled at the executing edge; the register updates on that edge.
- out_port changes on the edge that executes OUT and holds its value until the next OUT or reset.
- Reset asserted mid-program: all state is cleared at once. No partial instruction survives.

## Structure
- td4_pkg holds:
  - opcode enum (op_e) with the 12 defined encodings
  - widths DATA_W=4, ADDR_W=4, INSN_W=8
  - struct for decoded controls: src_sel, dst_sel, is_jmp, is_jnc, valid
- Natural sub-module: td4_decode, purely combinational, rom_data[7:4] -> decoded controls. The core holds only the registers, the adder and the PC logic.

## Test plan
- Reset with en=1, in_port=5, program {0111_0000, 0010_0000, 0000_0001, 0000_0001, 0100_0000, 1001_0000, 1111_0110}, then 6 edges -> out_port=7, B=7. The following edges keep PC=6 and out_port=7.
- A wrap: MOV A,15 then ADD A,1 -> A=0, C=1. A following JNC 9 is not taken (PC=3). After a C-clearing MOV, JNC 9 is taken (PC=9).
- en held low for 5 cycles mid-program -> rom_addr, A, B, C and out_port are unchanged; execution resumes at the same address.
- Program of NOPs (1000_0000 everywhere) -> PC steps 0..15, wraps to 0, and no other state changes.
- OUT Im with rom_data=1011_1010 -> out_port=10 on that edge; C=0.
- rst_n pulsed low asynchronously between edges while out_port=7, PC=6 -> all outputs 0 immediately; the next enabled edge fetches from address 0.
